// File: rtl/check_node_message_generator.sv
// -----------------------------------------------------------------------------
// check_node_message_generator
//
// Serialises the check-to-variable messages of one min-sum check node. On an
// accepted start the block snapshots the min / second-min magnitudes, the
// position of the minimum and the sign bit of every incoming edge message. It
// then emits one IEEE-754 word per edge over a valid/ready handshake. Each word
// carries:
//   sign = XOR of all edge signs XOR own edge sign  (extrinsic sign)
//   mag  = second_min on the edge holding the minimum, min everywhere else
//
// Ports
//   clk         single clock, rising edge
//   reset_n     synchronous active-low reset
//   start       begin one check node (sampled in IDLE only)
//   min         absolute minimum magnitude (sign bit ignored)
//   second_min  absolute second minimum magnitude (sign bit ignored)
//   pos         edge index of the minimum
//   inputs      DEG incoming messages, edge j at [W*j +: W]
//   msg_out     outgoing message (registered)
//   msg_index   edge index of msg_out (registered)
//   msg_valid   qualifies msg_out / msg_index (registered)
//   msg_ready   consumer accept
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle pulse after the last message is accepted
//   parity_ok   (CN_PARITY_FLAG_EN only) ~total_sign of the current node
//
// Optional feature macro: CN_PARITY_FLAG_EN adds the parity_ok output.
//
// Timing with msg_ready held high: start sampled at edge 0, LOAD after edge 0,
// SEND after edge 1, first valid word after edge 2, last word accepted at edge
// DEG+2, done visible after edge DEG+3.
// -----------------------------------------------------------------------------
module check_node_message_generator #(
    parameter int DEG = 40,
    parameter int W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [W-1:0]     min,
    input  logic [W-1:0]     second_min,
    input  logic [5:0]       pos,
    input  logic [W*DEG-1:0] inputs,
    output logic [W-1:0]     msg_out,
    output logic [5:0]       msg_index,
    output logic             msg_valid,
    input  logic             msg_ready,
    output logic             busy,
    output logic             done
`ifdef CN_PARITY_FLAG_EN
    ,
    output logic             parity_ok
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [5:0] LAST = 6'(DEG - 1);
    localparam logic [5:0] DEG6 = 6'(DEG);

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [5:0]     pos_q, pos_d;
    logic [W-2:0]   min_q, min_d;
    logic [W-2:0]   smin_q, smin_d;
    logic [DEG-1:0] sign_q, sign_d;
    logic           tsign_q, tsign_d;
    logic [W-1:0]   out_q, out_d;
    logic [5:0]     idx_q, idx_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
`ifdef CN_PARITY_FLAG_EN
    logic           parity_q, parity_d;
`endif

    // Only the sign bit of each incoming edge message is needed.
    logic [DEG-1:0] sign_in;
    for (genvar j = 0; j < DEG; j++) begin : g_sign
        assign sign_in[j] = inputs[W*j + W - 1];
    end

    // Magnitude bits of inputs and the sign bits of min / second_min are
    // deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{min[W-1], second_min[W-1], inputs};

    // Word to be loaded into the output register: the current index on the
    // first SEND cycle (output register still empty), otherwise the next one.
    // sel_idx only reaches DEG on the final accept, where the word is not used.
    // Because sel_idx stays below DEG when used, a captured pos >= DEG never
    // matches and every word falls back to min.
    logic [5:0]   sel_idx;
    logic         sel_sign;
    logic [W-1:0] sel_word;

    always_comb begin
        sel_idx  = valid_q ? 6'(cnt_q + 6'd1) : cnt_q;
        sel_sign = 1'b0;
        if (sel_idx < DEG6) begin
            sel_sign = sign_q[sel_idx];
        end
        sel_word = {tsign_q ^ sel_sign, (sel_idx == pos_q) ? smin_q : min_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        min_d    = min_q;
        smin_d   = smin_q;
        sign_d   = sign_q;
        tsign_d  = tsign_q;
        out_d    = out_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
`ifdef CN_PARITY_FLAG_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    min_d   = min[W-2:0];
                    smin_d  = second_min[W-2:0];
                    pos_d   = pos;
                    sign_d  = sign_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tsign_d  = ^sign_q;
`ifdef CN_PARITY_FLAG_EN
                parity_d = ~(^sign_q);
`endif
                cnt_d    = 6'd0;
                state_d  = SEND;
            end
            SEND: begin
                if (!valid_q) begin
                    // Prime the output register with the first word.
                    valid_d = 1'b1;
                    idx_d   = sel_idx;
                    out_d   = sel_word;
                end else if (msg_ready) begin
                    if (cnt_q == LAST) begin
                        valid_d = 1'b0;
                        state_d = FINISH;
                    end else begin
                        cnt_d = sel_idx;
                        idx_d = sel_idx;
                        out_d = sel_word;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pos_q    <= '0;
            min_q    <= '0;
            smin_q   <= '0;
            sign_q   <= '0;
            tsign_q  <= 1'b0;
            out_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef CN_PARITY_FLAG_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            min_q    <= min_d;
            smin_q   <= smin_d;
            sign_q   <= sign_d;
            tsign_q  <= tsign_d;
            out_q    <= out_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef CN_PARITY_FLAG_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign msg_out   = out_q;
    assign msg_index = idx_q;
    assign msg_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
`ifdef CN_PARITY_FLAG_EN
    assign parity_ok = parity_q;
`endif

endmodule

// File: tb/tb_check_node_message_generator.sv
module tb_check_node_message_generator;

    localparam int DEG = 40;
    localparam int W   = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             msg_ready = 1'b1;
    logic [W-1:0]     min_in = '0;
    logic [W-1:0]     smin_in = '0;
    logic [5:0]       pos_in = '0;
    logic [W*DEG-1:0] inputs_in = '0;
    logic [W-1:0]     msg_out;
    logic [5:0]       msg_index;
    logic             msg_valid;
    logic             busy;
    logic             done;
`ifdef CN_PARITY_FLAG_EN
    logic             parity_ok;
`endif

    int checks = 0;
    int errors = 0;

    check_node_message_generator #(.DEG(DEG), .W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .min        (min_in),
        .second_min (smin_in),
        .pos        (pos_in),
        .inputs     (inputs_in),
        .msg_out    (msg_out),
        .msg_index  (msg_index),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .busy       (busy),
        .done       (done)
`ifdef CN_PARITY_FLAG_EN
        ,
        .parity_ok  (parity_ok)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edge j magnitude is arbitrary; only its sign bit matters.
    task automatic load_cfg(input logic [31:0] mn, input logic [31:0] smn,
                            input logic [5:0] p, input logic [DEG-1:0] neg);
        min_in  = mn;
        smin_in = smn;
        pos_in  = p;
        for (int j = 0; j < DEG; j++) begin
            inputs_in[W*j +: W] = {neg[j], 31'(32'h3E000000 + j)};
        end
    endtask

    // start sampled at the next edge (edge 0); returns just after edge 0.
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (msg_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            msg_out !== 32'h0 || msg_index !== 6'd0)
            $display("FAIL reset_state: got v=%b b=%b d=%b out=%h idx=%0d want 0 0 0 0 0",
                     msg_valid, busy, done, msg_out, msg_index);
        if (msg_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            msg_out !== 32'h0 || msg_index !== 6'd0) errors++;
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int e;
        logic [31:0] exp;
        load_cfg(32'h3F800000, 32'h40000000, 6'd5, '0);
        launch();
        e = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_load: busy=%b want 1", busy);
        end
        while (!msg_valid && e < 8) begin step(); e++; end
        checks++;
        if (e != 2) begin
            errors++;
            $display("FAIL basic_first_valid: edges=%0d want 2", e);
        end
        for (int k = 0; k < DEG; k++) begin
            exp = (k == 5) ? 32'h40000000 : 32'h3F800000;
            checks++;
            if (msg_valid !== 1'b1 || msg_index !== 6'(k) || msg_out !== exp) begin
                errors++;
                $display("FAIL basic_msg: v=%b idx=%0d out=%h want idx=%0d out=%h",
                         msg_valid, msg_index, msg_out, k, exp);
            end
            step(); e++;
        end
        while (!done && e < 60) begin step(); e++; end
        checks++;
        if (e != 43) begin
            errors++;
            $display("FAIL basic_done_latency: edges=%0d want 43", e);
        end
`ifdef CN_PARITY_FLAG_EN
        checks++;
        if (parity_ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_parity: got %b want 1", parity_ok);
        end
`endif
        step();
        checks++;
        if (done !== 1'b0 || msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b v=%b want 0 0", done, msg_valid);
        end
    endtask

    task automatic test_sign();
        int e;
        logic [31:0] exp;
        logic [DEG-1:0] neg;
        neg = '0;
        neg[7] = 1'b1;
        load_cfg(32'h3F800000, 32'h40000000, 6'd5, neg);
        launch();
        e = 0;
        while (!msg_valid && e < 8) begin step(); e++; end
        for (int k = 0; k < DEG; k++) begin
            if (k == 7)      exp = 32'h3F800000;
            else if (k == 5) exp = 32'hC0000000;
            else             exp = 32'hBF800000;
            checks++;
            if (msg_valid !== 1'b1 || msg_index !== 6'(k) || msg_out !== exp) begin
                errors++;
                $display("FAIL sign_msg: idx=%0d out=%h want idx=%0d out=%h",
                         msg_index, msg_out, k, exp);
            end
            step(); e++;
        end
`ifdef CN_PARITY_FLAG_EN
        checks++;
        if (parity_ok !== 1'b0) begin
            errors++;
            $display("FAIL sign_parity: got %b want 0", parity_ok);
        end
`endif
        while (!done && e < 60) begin step(); e++; end
        checks++;
        if (e != 43) begin
            errors++;
            $display("FAIL sign_done_latency: edges=%0d want 43", e);
        end
        step();
    endtask

    task automatic test_stall();
        int e;
        logic [31:0] exp;
        load_cfg(32'h3F800000, 32'h40000000, 6'd5, '0);
        launch();
        e = 0;
        while (!msg_valid && e < 8) begin step(); e++; end
        for (int k = 0; k < DEG; k++) begin
            exp = (k == 5) ? 32'h40000000 : 32'h3F800000;
            checks++;
            if (msg_valid !== 1'b1 || msg_index !== 6'(k) || msg_out !== exp) begin
                errors++;
                $display("FAIL stall_msg: idx=%0d out=%h want idx=%0d out=%h",
                         msg_index, msg_out, k, exp);
            end
            if (k == 10) begin
                msg_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step(); e++;
                    checks++;
                    if (msg_valid !== 1'b1 || msg_index !== 6'd10 || msg_out !== 32'h3F800000) begin
                        errors++;
                        $display("FAIL stall_hold: v=%b idx=%0d out=%h want 1 10 3f800000",
                                 msg_valid, msg_index, msg_out);
                    end
                end
                msg_ready = 1'b1;
            end
            step(); e++;
        end
        while (!done && e < 60) begin step(); e++; end
        checks++;
        if (e != 46) begin
            errors++;
            $display("FAIL stall_done_latency: edges=%0d want 46", e);
        end
        step();
    endtask

    task automatic test_pos_oob();
        int e;
        logic [31:0] exp;
        logic [DEG-1:0] neg;
        neg = '0;
        neg[0] = 1'b1;
        neg[1] = 1'b1;
        // Sign bits of min/second_min set on purpose: they must be ignored.
        load_cfg(32'hBF800000, 32'hC0000000, 6'd50, neg);
        launch();
        e = 0;
        while (!msg_valid && e < 8) begin step(); e++; end
        for (int k = 0; k < DEG; k++) begin
            exp = {neg[k], 31'h3F800000};
            checks++;
            if (msg_valid !== 1'b1 || msg_index !== 6'(k) || msg_out !== exp) begin
                errors++;
                $display("FAIL oob_msg: idx=%0d out=%h want idx=%0d out=%h",
                         msg_index, msg_out, k, exp);
            end
            step(); e++;
        end
        while (!done && e < 60) begin step(); e++; end
        step();
    endtask

    task automatic test_reset_mid();
        int e;
        logic [DEG-1:0] neg;
        load_cfg(32'h3F800000, 32'h40000000, 6'd5, '0);
        launch();
        repeat (22) step();
        checks++;
        if (msg_index !== 6'd20 || msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: idx=%0d v=%b want 20 1", msg_index, msg_valid);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (msg_valid !== 1'b0 || busy !== 1'b0 || msg_index !== 6'd0 || msg_out !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_state: v=%b b=%b idx=%0d out=%h want 0 0 0 0",
                     msg_valid, busy, msg_index, msg_out);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: v=%b want 0", msg_valid);
        end
        neg = '0;
        neg[0] = 1'b1;
        load_cfg(32'h40400000, 32'h40800000, 6'd0, neg);
        launch();
        e = 0;
        while (!msg_valid && e < 8) begin step(); e++; end
        checks++;
        if (e != 2 || msg_index !== 6'd0 || msg_out !== 32'h40800000) begin
            errors++;
            $display("FAIL rstmid_restart0: edges=%0d idx=%0d out=%h want 2 0 40800000",
                     e, msg_index, msg_out);
        end
        step(); e++;
        checks++;
        if (msg_index !== 6'd1 || msg_out !== 32'hC0400000) begin
            errors++;
            $display("FAIL rstmid_restart1: idx=%0d out=%h want 1 c0400000", msg_index, msg_out);
        end
        while (!done && e < 60) begin step(); e++; end
        checks++;
        if (e != 43) begin
            errors++;
            $display("FAIL rstmid_done: edges=%0d want 43", e);
        end
        step();
    endtask

    task automatic test_ignored_start();
        int e;
        logic [31:0] exp;
        load_cfg(32'h3F800000, 32'h40000000, 6'd5, '0);
        launch();
        e = 0;
        while (!msg_valid && e < 8) begin step(); e++; end
        for (int k = 0; k < DEG; k++) begin
            exp = (k == 5) ? 32'h40000000 : 32'h3F800000;
            checks++;
            if (msg_valid !== 1'b1 || msg_index !== 6'(k) || msg_out !== exp) begin
                errors++;
                $display("FAIL ignstart_msg: idx=%0d out=%h want idx=%0d out=%h",
                         msg_index, msg_out, k, exp);
            end
            if (k == 3) begin
                start = 1'b1;
                load_cfg(32'h40400000, 32'h3F000000, 6'd4, '1);
            end
            if (k == 4) start = 1'b0;
            step(); e++;
        end
        // Now in the FINISH cycle: a start here must be ignored.
        start = 1'b1;
        step(); e++;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || e != 43) begin
            errors++;
            $display("FAIL ignstart_finish: done=%b busy=%b edges=%0d want 1 0 43", done, busy, e);
        end
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || msg_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignstart_idle: busy=%b v=%b done=%b want 0 0 0", busy, msg_valid, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_stall();
        test_pos_oob();
        test_reset_mid();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/check_node_message_generator.md
CHECK_NODE_MESSAGE_GENERATOR -- requirements
Module: check_node_message_generator

Interface
REQ-001 SHALL have parameter DEG, default 40, meaning the check-node degree (number of edges); 2 <= DEG <= 63.
REQ-002 SHALL have parameter W, default 32, meaning the message width (IEEE-754 single-precision word, bit W-1 = sign).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset; it is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, a request to begin generating messages for one check node.
REQ-006 SHALL have port min, input, W, the absolute minimum; bit W-1 is ignored.
REQ-007 SHALL have port second_min, input, W, the absolute second minimum; bit W-1 is ignored.
REQ-008 SHALL have port pos, input, 6, the edge index of the minimum.
REQ-009 SHALL have port inputs, input, W*DEG, the incoming variable-to-check messages; edge j occupies bits [W*j+W-1 : W*j].
REQ-010 SHALL have port msg_out, output, W, the outgoing check-to-variable message.
REQ-011 SHALL have port msg_index, output, 6, the edge index of msg_out.
REQ-012 SHALL have port msg_valid, output, 1, which qualifies msg_out and msg_index.
REQ-013 SHALL have port msg_ready, input, 1, the consumer-accept signal.
REQ-014 SHALL have port busy, output, 1, which is high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse after the last message is accepted.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, LOAD, SEND, FINISH.
REQ-017 In IDLE with start=1, the block SHALL capture the following on that edge and go to LOAD: min[W-2:0], second_min[W-2:0], pos, and the DEG sign bits inputs[W*j+W-1].
REQ-018 SHALL ignore start in every state except IDLE; captured values stay unchanged until the next accepted start.
REQ-019 SHALL compute total_sign, the XOR of all DEG captured sign bits, in LOAD, and go to SEND after exactly one cycle with index counter = 0.
REQ-020 In SEND, msg_valid SHALL be 1, msg_index SHALL equal the counter, and msg_out SHALL equal {total_sign XOR sign[counter], mag}.
REQ-021 mag SHALL equal captured second_min if counter == captured pos, else captured min.
REQ-022 If captured pos >= DEG, every message SHALL use min.
REQ-023 The counter SHALL advance only on a cycle with msg_valid & msg_ready; msg_out and msg_index SHALL hold stable while msg_ready=0.
REQ-024 Acceptance at counter == DEG-1 SHALL move the FSM to FINISH with no counter wrap.
REQ-025 FINISH SHALL assert done=1 for one cycle, then return to IDLE; a start in that cycle is ignored.
REQ-026 Minimum latency SHALL be: start edge, then the first msg_valid two cycles later, then done DEG+3 cycles after start with msg_ready held 1.
REQ-027 msg_out, msg_index and msg_valid SHALL be registered, with no combinational path from msg_ready to msg_valid.

Reset
REQ-028 When reset_n=0 at a clock edge, the block SHALL enter IDLE and clear the counter.
REQ-029 Reset SHALL clear msg_valid, busy, done, msg_out, msg_index and all captured registers to 0, including mid-SEND, with no further messages emitted.
REQ-030 Reset SHALL take priority over start and msg_ready.

Configuration
REQ-031 With macro CN_PARITY_FLAG_EN defined, the block SHALL add output parity_ok (1 bit).
REQ-032 parity_ok SHALL be reset to 0, load ~total_sign at the LOAD-to-SEND edge, and hold until the next LOAD.
REQ-033 Without CN_PARITY_FLAG_EN, parity_ok and its register SHALL be absent and all other behaviour identical.

Verification
REQ-034 DEG=40, all edges positive, min=0x3F800000, second_min=0x40000000, pos=5, msg_ready=1 -> 40 messages indices 0..39; index 5 = 0x40000000, others 0x3F800000; done at cycle 43.
REQ-035 Only edge 7 negative, same magnitudes, pos=5 -> total_sign=1; index 7 = 0x3F800000, all other indices have bit 31 set; parity_ok=0 if enabled.
REQ-036 msg_ready low for 3 cycles at index 10 -> msg_out and msg_index held at index 10 for 4 cycles, no index skipped, done delayed by 3.
REQ-037 pos=50 -> all 40 messages carry min magnitude.
REQ-038 reset_n=0 at index 20 -> next cycle msg_valid=0, busy=0, msg_index=0; new start restarts at index 0.
REQ-039 Second start during SEND and start in the FINISH cycle -> both ignored; captured values unchanged.
